// File: rtl/vram_bus_arbiter_pkg.sv
// Shared types and address-map constants for the VRAM bus arbiter.
package vram_bus_arbiter_pkg;

  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned WORD_ADDR_W = 15;
  localparam int unsigned REG_OFF_W   = 6;

  localparam logic [ADDR_W-1:0] DEF_PERIPH_BASE = 19'h1F9C0;
  localparam logic [ADDR_W-1:0] DEF_VRAM_TOP    = 19'h1FFFF;
  localparam logic [ADDR_W-1:0] PSG_SPAN        = 19'h0003F;
  localparam logic [ADDR_W-1:0] PAL_BASE        = 19'h1FA00;
  localparam logic [ADDR_W-1:0] SPR_BASE        = 19'h1FC00;

  typedef enum logic [2:0] {
    REG_VRAM,
    REG_PSG,
    REG_PAL,
    REG_SPR,
    REG_NONE
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } vid_state_e;

endpackage

// File: rtl/vram_bus_decode.sv
// Combinational CPU address to region decode.
module vram_bus_decode
  import vram_bus_arbiter_pkg::*;
#(
  parameter logic [18:0] PERIPH_BASE = DEF_PERIPH_BASE,
  parameter logic [18:0] VRAM_TOP    = DEF_VRAM_TOP
) (
  input  logic [18:0] addr,
  output region_e     region_c
);

  logic [19:0] psg_top;

  // Compare in 20 bits so a high PERIPH_BASE cannot wrap the PSG window.
  assign psg_top = 20'(PERIPH_BASE) + 20'(PSG_SPAN);

  always_comb begin
    region_c = REG_NONE;
    if (addr > VRAM_TOP) begin
      region_c = REG_NONE;
    end else if (addr < PERIPH_BASE) begin
      region_c = REG_VRAM;
    end else if (20'(addr) <= psg_top) begin
      region_c = REG_PSG;
    end else if ((addr >= PAL_BASE) && (addr < SPR_BASE)) begin
      region_c = REG_PAL;
    end else if (addr >= SPR_BASE) begin
      region_c = REG_SPR;
    end
  end

endmodule

// File: rtl/vram_bus_arbiter.sv
// CPU/video arbiter for the VRAM port plus CPU peripheral register routing.
// CPU VRAM accesses always win; a blocked video fetch waits in PEND.
module vram_bus_arbiter
  import vram_bus_arbiter_pkg::*;
#(
  parameter logic [18:0] PERIPH_BASE = DEF_PERIPH_BASE,
  parameter logic [18:0] VRAM_TOP    = DEF_VRAM_TOP
) (
  input  logic        bm_clk,
  input  logic        bm_reset,
  input  logic [18:0] bm_addr,
  input  logic [7:0]  bm_wrdata,
  input  logic        bm_strobe,
  input  logic        bm_write,
  output logic [7:0]  bm_rddata,
  input  logic [14:0] vid_addr,
  input  logic        vid_strobe,
  output logic        vid_ack,
  output logic [31:0] vid_rddata,
  output logic        vid_rddata_valid,
  output logic [14:0] ram_addr,
  output logic [31:0] ram_wrdata,
  output logic [3:0]  ram_wrbytesel,
  output logic        ram_write,
  input  logic [31:0] ram_rddata,
  output logic [5:0]  periph_addr,
  output logic [7:0]  periph_wrdata,
  output logic        periph_write,
  output logic        psg_strobe,
  output logic        pal_strobe,
  output logic        spr_strobe,
  input  logic [7:0]  psg_rddata,
  input  logic [7:0]  pal_rddata,
  input  logic [7:0]  spr_rddata
);

  region_e    region_c;
  logic       cpu_req_c, cpu_vram_c, cpu_periph_c, vid_grant_c;
  vid_state_e state_q, state_d;

  logic       cpu_rd_q, cpu_rd_d;
  region_e    rd_region_q, rd_region_d;
  logic [1:0] rd_byte_q, rd_byte_d;
  logic [7:0] bm_rddata_q, bm_rddata_d, rd_sel_c;
  logic       vid_valid_q, vid_valid_d;
  logic [31:0] vid_rddata_q, vid_rddata_d;

  vram_bus_decode #(
    .PERIPH_BASE (PERIPH_BASE),
    .VRAM_TOP    (VRAM_TOP)
  ) u_decode (
    .addr     (bm_addr),
    .region_c (region_c)
  );

  // Every combinational issue path is gated by reset so outputs read zero.
  assign cpu_req_c    = bm_strobe & ~bm_reset;
  assign cpu_vram_c   = cpu_req_c && (region_c == REG_VRAM);
  assign cpu_periph_c = cpu_req_c && ((region_c == REG_PSG) || (region_c == REG_PAL) ||
                                      (region_c == REG_SPR));

  always_comb begin
    state_d     = state_q;
    vid_grant_c = 1'b0;
    if (!bm_reset) begin
      case (state_q)
        ST_IDLE: begin
          if (vid_strobe) begin
            if (cpu_vram_c) state_d = ST_PEND;
            else            vid_grant_c = 1'b1;
          end
        end
        ST_PEND: begin
          if (!cpu_vram_c) begin
            vid_grant_c = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr      = '0;
    ram_wrdata    = '0;
    ram_wrbytesel = '0;
    ram_write     = 1'b0;
    if (cpu_vram_c) begin
      ram_addr      = bm_addr[16:2];
      ram_wrbytesel = 4'b0001 << bm_addr[1:0];
      ram_wrdata    = {4{bm_wrdata}};
      ram_write     = bm_write;
    end else if (vid_grant_c) begin
      ram_addr = vid_addr;
    end
  end

  always_comb begin
    periph_addr   = '0;
    periph_wrdata = '0;
    periph_write  = 1'b0;
    psg_strobe    = 1'b0;
    pal_strobe    = 1'b0;
    spr_strobe    = 1'b0;
    if (cpu_periph_c) begin
      periph_addr   = bm_addr[5:0];
      periph_wrdata = bm_wrdata;
      periph_write  = bm_write;
      psg_strobe    = (region_c == REG_PSG);
      pal_strobe    = (region_c == REG_PAL);
      spr_strobe    = (region_c == REG_SPR);
    end
  end

  // Read return: data sources answer one cycle after issue, so the byte is
  // muxed straight through that cycle and then held in bm_rddata_q.
  always_comb begin
    cpu_rd_d    = cpu_req_c & ~bm_write;
    rd_region_d = cpu_rd_d ? region_c : rd_region_q;
    rd_byte_d   = cpu_rd_d ? bm_addr[1:0] : rd_byte_q;
    rd_sel_c    = 8'h00;
    case (rd_region_q)
      REG_VRAM: begin
        case (rd_byte_q)
          2'd0:    rd_sel_c = ram_rddata[7:0];
          2'd1:    rd_sel_c = ram_rddata[15:8];
          2'd2:    rd_sel_c = ram_rddata[23:16];
          default: rd_sel_c = ram_rddata[31:24];
        endcase
      end
      REG_PSG: rd_sel_c = psg_rddata;
      REG_PAL: rd_sel_c = pal_rddata;
      REG_SPR: rd_sel_c = spr_rddata;
      default: rd_sel_c = 8'h00;
    endcase
    bm_rddata_d  = cpu_rd_q ? rd_sel_c : bm_rddata_q;
    vid_valid_d  = vid_grant_c;
    vid_rddata_d = vid_valid_q ? ram_rddata : vid_rddata_q;
  end

  assign bm_rddata        = bm_rddata_d;
  assign vid_ack          = vid_grant_c;
  assign vid_rddata_valid = vid_valid_q;
  assign vid_rddata       = vid_rddata_d;

  always_ff @(posedge bm_clk or posedge bm_reset) begin
    if (bm_reset) begin
      state_q      <= ST_IDLE;
      cpu_rd_q     <= 1'b0;
      rd_region_q  <= REG_NONE;
      rd_byte_q    <= 2'd0;
      bm_rddata_q  <= 8'h00;
      vid_valid_q  <= 1'b0;
      vid_rddata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cpu_rd_q     <= cpu_rd_d;
      rd_region_q  <= rd_region_d;
      rd_byte_q    <= rd_byte_d;
      bm_rddata_q  <= bm_rddata_d;
      vid_valid_q  <= vid_valid_d;
      vid_rddata_q <= vid_rddata_d;
    end
  end

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Randomized bench for vram_bus_arbiter against a transaction-level model
// with a one-cycle-latency VRAM device and shadow memory.
module tb_vram_bus_arbiter;

  logic        bm_clk = 1'b0;
  logic        bm_reset = 1'b1;
  logic [18:0] bm_addr = '0;
  logic [7:0]  bm_wrdata = '0;
  logic        bm_strobe = 1'b0;
  logic        bm_write = 1'b0;
  logic [7:0]  bm_rddata;
  logic [14:0] vid_addr = '0;
  logic        vid_strobe = 1'b0;
  logic        vid_ack;
  logic [31:0] vid_rddata;
  logic        vid_rddata_valid;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata = '0;
  logic [5:0]  periph_addr;
  logic [7:0]  periph_wrdata;
  logic        periph_write;
  logic        psg_strobe, pal_strobe, spr_strobe;
  logic [7:0]  psg_rddata = '0, pal_rddata = '0, spr_rddata = '0;

  vram_bus_arbiter dut (
    .bm_clk(bm_clk), .bm_reset(bm_reset), .bm_addr(bm_addr), .bm_wrdata(bm_wrdata),
    .bm_strobe(bm_strobe), .bm_write(bm_write), .bm_rddata(bm_rddata),
    .vid_addr(vid_addr), .vid_strobe(vid_strobe), .vid_ack(vid_ack),
    .vid_rddata(vid_rddata), .vid_rddata_valid(vid_rddata_valid),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
    .ram_write(ram_write), .ram_rddata(ram_rddata),
    .periph_addr(periph_addr), .periph_wrdata(periph_wrdata), .periph_write(periph_write),
    .psg_strobe(psg_strobe), .pal_strobe(pal_strobe), .spr_strobe(spr_strobe),
    .psg_rddata(psg_rddata), .pal_rddata(pal_rddata), .spr_rddata(spr_rddata)
  );

  always #5 bm_clk = ~bm_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [14:0] i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // VRAM device: byte-enabled writes, read data one cycle after the address.
  bit [31:0] dev_mem [32768];
  bit        dev_wr  [32768];
  function automatic logic [31:0] dev_word(input logic [14:0] i);
    return dev_wr[i] ? dev_mem[i] : init_word(i);
  endfunction
  always @(posedge bm_clk) begin
    if (ram_write) begin
      dev_mem[ram_addr] <= merge(dev_word(ram_addr), ram_wrdata, ram_wrbytesel);
      dev_wr[ram_addr]  <= 1'b1;
    end
    ram_rddata <= dev_word(ram_addr);
  end

  // Model: shadow memory plus the outstanding CPU read and video fetch.
  bit [31:0] sh_mem [32768];
  bit        sh_wr  [32768];
  function automatic logic [31:0] sh_word(input logic [14:0] i);
    return sh_wr[i] ? sh_mem[i] : init_word(i);
  endfunction

  bit          m_rd_pend = 0;
  int          m_rd_rg = 4;
  int          m_rd_byte = 0;
  logic [31:0] m_rd_word = '0;
  logic [7:0]  m_bm_rd = '0;
  bit          m_vid_pend = 0;
  logic [31:0] m_vid_word = '0;
  logic [31:0] m_vid_data = '0;
  bit          m_drop = 0;
  bit          auto_vid = 0;
  bit          pal_fixed = 0;
  logic [7:0]  pal_val = '0;

  logic        obs_vid_ack, obs_write, obs_vid_valid, obs_psg, obs_pal, obs_spr;
  logic [14:0] obs_ram_addr;
  logic [3:0]  obs_sel;
  logic [31:0] obs_wdata, obs_vid_data;
  logic [5:0]  obs_periph_addr;

  // 0 VRAM, 1 PSG, 2 PAL, 3 SPR, 4 NONE
  function automatic int region_of(input logic [18:0] a);
    if (a < 19'h1F9C0) return 0;
    if (a <= 19'h1F9FF) return 1;
    if (a <= 19'h1FBFF) return 2;
    if (a <= 19'h1FFFF) return 3;
    return 4;
  endfunction

  task automatic cyc(input logic s, input logic w, input logic [18:0] a, input logic [7:0] d);
    int          rg;
    bit          cpu_vram, exp_ack;
    logic [14:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_sel;
    logic        e_write;
    @(negedge bm_clk);
    if (m_drop) vid_strobe = 1'b0;
    m_drop = 0;
    if (auto_vid && !vid_strobe && $urandom_range(0, 2) == 0) begin
      vid_strobe = 1'b1;
      vid_addr = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
    end
    bm_strobe = s; bm_write = w; bm_addr = a; bm_wrdata = d;
    psg_rddata = 8'($urandom);
    pal_rddata = pal_fixed ? pal_val : 8'($urandom);
    spr_rddata = 8'($urandom);
    #1;
    rg = region_of(a);
    cpu_vram = s && (rg == 0);
    exp_ack = vid_strobe && !cpu_vram;
    e_addr = '0; e_wdata = '0; e_sel = '0; e_write = 1'b0;
    if (cpu_vram) begin
      e_addr = a[16:2]; e_wdata = {4{d}}; e_sel = 4'(1 << a[1:0]); e_write = w;
    end else if (exp_ack) begin
      e_addr = vid_addr;
    end
    if (m_rd_pend) begin
      case (m_rd_rg)
        0:       m_bm_rd = m_rd_word[8*m_rd_byte +: 8];
        1:       m_bm_rd = psg_rddata;
        2:       m_bm_rd = pal_rddata;
        3:       m_bm_rd = spr_rddata;
        default: m_bm_rd = 8'h00;
      endcase
    end
    if (m_vid_pend) m_vid_data = m_vid_word;
    obs_vid_ack = vid_ack; obs_ram_addr = ram_addr; obs_sel = ram_wrbytesel;
    obs_wdata = ram_wrdata; obs_write = ram_write; obs_vid_valid = vid_rddata_valid;
    obs_vid_data = vid_rddata; obs_psg = psg_strobe; obs_pal = pal_strobe;
    obs_spr = spr_strobe; obs_periph_addr = periph_addr;
    check_eq("ram_addr", 32'(ram_addr), 32'(e_addr));
    check_eq("ram_wrdata", ram_wrdata, e_wdata);
    check_eq("ram_wrbytesel", 32'(ram_wrbytesel), 32'(e_sel));
    check_eq("ram_write", 32'(ram_write), 32'(e_write));
    check_eq("vid_ack", 32'(vid_ack), 32'(exp_ack));
    check_eq("strobes", {29'd0, psg_strobe, pal_strobe, spr_strobe},
             {29'd0, s && rg == 1, s && rg == 2, s && rg == 3});
    if (s && rg >= 1 && rg <= 3) begin
      check_eq("periph_addr", 32'(periph_addr), 32'(a[5:0]));
      check_eq("periph_write", 32'(periph_write), 32'(w));
      check_eq("periph_wrdata", 32'(periph_wrdata), 32'(d));
    end
    check_eq("bm_rddata", 32'(bm_rddata), 32'(m_bm_rd));
    check_eq("vid_valid", 32'(vid_rddata_valid), 32'(m_vid_pend));
    check_eq("vid_rddata", vid_rddata, m_vid_data);
    @(posedge bm_clk);
    if (cpu_vram && w) begin
      sh_mem[a[16:2]] = merge(sh_word(a[16:2]), {4{d}}, 4'(1 << a[1:0]));
      sh_wr[a[16:2]] = 1;
    end
    m_rd_pend = s && !w;
    m_rd_rg = rg;
    m_rd_byte = int'(a[1:0]);
    m_rd_word = sh_word(a[16:2]);
    m_vid_pend = exp_ack;
    if (exp_ack) begin
      m_vid_word = sh_word(vid_addr);
      m_drop = 1;
    end
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge bm_clk);
    bm_reset = 1'b1; bm_strobe = 1'b1; bm_write = 1'b1; bm_addr = 19'h00010;
    bm_wrdata = 8'hFF; vid_strobe = 1'b1;
    #1;
    check_eq("rst_ram", {ram_addr, ram_wrbytesel, 12'd0, ram_write}, 32'h0);
    check_eq("rst_ram_wrdata", ram_wrdata, 32'h0);
    check_eq("rst_vid", {29'd0, vid_ack, vid_rddata_valid, 1'b0}, 32'h0);
    check_eq("rst_vid_rddata", vid_rddata, 32'h0);
    check_eq("rst_bm_rddata", 32'(bm_rddata), 32'h0);
    check_eq("rst_periph", {14'd0, periph_addr, periph_wrdata, periph_write,
                            psg_strobe, pal_strobe, spr_strobe}, 32'h0);
    repeat (ncyc) @(posedge bm_clk);
    @(negedge bm_clk);
    #1;
    check_eq("rst_hold_ack", 32'(vid_ack), 32'h0);
    check_eq("rst_hold_out", {bm_rddata, 23'd0, vid_rddata_valid}, 32'h0);
    bm_reset = 1'b0; bm_strobe = 1'b0; bm_write = 1'b0; vid_strobe = 1'b0;
    m_rd_pend = 0; m_bm_rd = '0; m_vid_pend = 0; m_vid_data = '0; m_drop = 0;
    @(posedge bm_clk);
    #1;
  endtask

  function automatic logic [18:0] rand_addr();
    logic [18:0] bnd [10];
    bnd = '{19'h1F9BF, 19'h1F9C0, 19'h1F9FF, 19'h1FA00, 19'h1FBFF,
            19'h1FC00, 19'h1FFFF, 19'h20000, 19'h7FFFF, 19'h00000};
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return 19'($urandom_range(0, 63));
      5:             return 19'h1F9C0 + 19'($urandom_range(0, 63));
      6:             return 19'h1FA00 + 19'($urandom_range(0, 511));
      7:             return 19'h1FC00 + 19'($urandom_range(0, 1023));
      8:             return 19'h20000 + 19'($urandom_range(0, 19'h5FFFF));
      default:       return bnd[$urandom_range(0, 9)];
    endcase
  endfunction

  initial begin
    logic        s, w;
    logic [18:0] a;
    logic [7:0]  d;
    do_reset(2);

    // Byte write lane and replication.
    cyc(1, 1, 19'h00005, 8'hA5);
    check_eq("d021_addr", 32'(obs_ram_addr), 32'h1);
    check_eq("d021_sel", 32'(obs_sel), 32'h2);
    check_eq("d021_wdata", obs_wdata, 32'hA5A5A5A5);
    check_eq("d021_write", 32'(obs_write), 32'h1);

    // Build 0x11223344 in word 1, read top byte back.
    cyc(1, 1, 19'h00004, 8'h44);
    cyc(1, 1, 19'h00005, 8'h33);
    cyc(1, 1, 19'h00006, 8'h22);
    cyc(1, 1, 19'h00007, 8'h11);
    cyc(1, 0, 19'h00007, 8'h00);
    cyc(0, 0, 19'h00000, 8'h00);
    check_eq("d022_rddata", 32'(bm_rddata), 32'h11);

    // Video collides with a CPU read, then is granted the following cycle.
    vid_strobe = 1'b1; vid_addr = 15'h0001;
    cyc(1, 0, 19'h00004, 8'h00);
    check_eq("d023_no_ack", 32'(obs_vid_ack), 32'h0);
    cyc(0, 0, 19'h00000, 8'h00);
    check_eq("d023_ack", 32'(obs_vid_ack), 32'h1);
    check_eq("d023_addr", 32'(obs_ram_addr), 32'h1);
    cyc(0, 0, 19'h00000, 8'h00);
    check_eq("d023_valid", 32'(obs_vid_valid), 32'h1);
    check_eq("d023_data", obs_vid_data, 32'h11223344);

    // Palette read.
    pal_fixed = 1; pal_val = 8'h3C;
    cyc(1, 0, 19'h1FA10, 8'h00);
    check_eq("d024_pal", {29'd0, obs_psg, obs_pal, obs_spr}, 32'h2);
    check_eq("d024_off", 32'(obs_periph_addr), 32'h10);
    cyc(0, 0, 19'h00000, 8'h00);
    check_eq("d024_rddata", 32'(bm_rddata), 32'h3C);
    pal_fixed = 0;

    // Unmapped read above the decoded window.
    cyc(1, 0, 19'h20000, 8'h00);
    check_eq("d025_nostrobe", {29'd0, obs_psg, obs_pal, obs_spr}, 32'h0);
    cyc(0, 0, 19'h00000, 8'h00);
    check_eq("d025_rddata", 32'(bm_rddata), 32'h0);

    // Write then immediate video read of the same word.
    cyc(1, 1, 19'h00009, 8'h5A);
    vid_strobe = 1'b1; vid_addr = 15'h0002;
    cyc(0, 0, 19'h00000, 8'h00);
    cyc(0, 0, 19'h00000, 8'h00);
    check_eq("d014_byte", 32'(obs_vid_data[15:8]), 32'h5A);

    // Reset while a video request is pending.
    vid_strobe = 1'b1; vid_addr = 15'h0003;
    cyc(1, 0, 19'h0000C, 8'h00);
    check_eq("pend_no_ack", 32'(obs_vid_ack), 32'h0);
    do_reset(2);
    cyc(0, 0, 19'h00000, 8'h00);
    check_eq("pend_dropped", 32'(obs_vid_ack), 32'h0);

    auto_vid = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        s = ($urandom_range(0, 2) != 0);
        w = 1'($urandom_range(0, 1));
        a = rand_addr();
        d = 8'($urandom);
        cyc(s, w, a, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_bus_arbiter.md
VRAM_BUS_ARBITER -- requirements
Module: vram_bus_arbiter

Interface
REQ-001 SHALL provide parameter PERIPH_BASE, default 19'h1F9C0: first peripheral address.
REQ-002 SHALL provide parameter VRAM_TOP, default 19'h1FFFF: last address decoded by this block.
REQ-003 SHALL use bm_reset as its reset: asynchronous, active-high. SHALL use bm_clk as its clock.
REQ-004 Ports, in order:
- bm_clk  in  1  clock
- bm_reset  in  1  reset
- bm_addr  in  19  CPU byte address
- bm_wrdata  in  8  CPU write data
- bm_strobe  in  1  one-cycle CPU access request
- bm_write  in  1  1=write, 0=read
- bm_rddata  out  8  CPU read data
- vid_addr  in  15  video fetch 32-bit word address
- vid_strobe  in  1  video request, held until vid_ack
- vid_ack  out  1  video request issued this cycle
- vid_rddata  out  32  video fetch data
- vid_rddata_valid  out  1  vid_rddata valid
- ram_addr  out  15  VRAM word address
- ram_wrdata  out  32  VRAM write data
- ram_wrbytesel  out  4  VRAM byte enables
- ram_write  out  1  VRAM write enable
- ram_rddata  in  32  VRAM read data, one cycle after issue
- periph_addr  out  6  peripheral register offset
- periph_wrdata  out  8  peripheral write data
- periph_write  out  1  peripheral write enable
- psg_strobe  out  1  PSG select
- pal_strobe  out  1  palette select
- spr_strobe  out  1  sprite attribute select
- psg_rddata  in  8  PSG read data
- pal_rddata  in  8  palette read data
- spr_rddata  in  8  sprite read data

Function
REQ-005 SHALL decode each bm_addr into one region:
- VRAM: below PERIPH_BASE.
- PSG: PERIPH_BASE..+0x3F.
- PAL: 0x1FA00..0x1FBFF.
- SPR: 0x1FC00..VRAM_TOP.
- NONE: above VRAM_TOP.
REQ-006 CPU VRAM access SHALL always take priority. On bm_strobe it SHALL be issued combinationally in the same cycle:
- ram_addr = bm_addr[16:2].
- ram_wrbytesel = one-hot of bm_addr[1:0].
- ram_wrdata = bm_wrdata replicated 4x.
- ram_write = bm_write.
REQ-007 bm_rddata SHALL be valid in the cycle after bm_strobe (fixed latency 1) and SHALL hold until the next CPU read.
REQ-008 bm_rddata SHALL be the byte of ram_rddata selected by the registered bm_addr[1:0].
REQ-009 Peripheral access: exactly one of psg_strobe/pal_strobe/spr_strobe SHALL pulse for one cycle, with periph_addr = bm_addr[5:0] and periph_write = bm_write. Read data SHALL return at latency 1 from the selected peripheral's rddata, chosen by the registered region.
REQ-010 NONE region: reads SHALL return 8'h00; writes SHALL be discarded; no strobe SHALL be issued.
REQ-011 Video arbiter SHALL be an FSM with states IDLE, PEND:
- IDLE, vid_strobe=1, no CPU VRAM access: issue ram_addr=vid_addr, ram_write=0, vid_ack=1; stay IDLE.
- IDLE, vid_strobe=1, CPU VRAM access this cycle: go to PEND, vid_ack=0.
- PEND, no CPU VRAM access: issue the video read, vid_ack=1, return to IDLE.
- PEND, CPU VRAM access again: stay PEND.
REQ-012 vid_rddata_valid SHALL pulse exactly one cycle after vid_ack, with vid_rddata = ram_rddata.
REQ-013 CPU peripheral or NONE accesses SHALL NOT block the video port.
REQ-014 A CPU VRAM write followed by a video read of the same word in the next cycle SHALL return the written byte.
REQ-015 With no grant, ram_write and ram_wrbytesel SHALL be 0.

Reset
REQ-016 While bm_reset is high, all outputs SHALL be 0 and the FSM SHALL be IDLE.
REQ-017 Reset mid-operation SHALL drop any pending video request without asserting vid_ack or vid_rddata_valid.
REQ-018 Data returns outstanding at reset SHALL NOT update bm_rddata or vid_rddata.

Structure
REQ-019 A shared package SHALL hold:
- the region enum (VRAM/PSG/PAL/SPR/NONE);
- PERIPH_BASE and the PAL/SPR base constants;
- the FSM state enum.
REQ-020 Address decode SHALL be one sub-module, vram_bus_decode (combinational region select); all sequencing SHALL stay in the top module.

Verification
REQ-021 CPU write bm_addr=19'h00005, data 8'hA5 -> ram_addr=1, ram_wrbytesel=4'b0010, ram_wrdata=32'hA5A5A5A5, ram_write=1 in the same cycle.
REQ-022 CPU read 19'h00007, ram_rddata=32'h11223344 -> bm_rddata=8'h11 one cycle after bm_strobe.
REQ-023 vid_strobe and CPU VRAM read in the same cycle -> CPU issued first; vid_ack the next cycle with ram_addr=vid_addr; vid_rddata_valid one cycle later.
REQ-024 CPU read 19'h1FA10 with pal_rddata=8'h3C -> pal_strobe one cycle, periph_addr=6'h10, bm_rddata=8'h3C next cycle.
REQ-025 CPU read 19'h1FFFF+1 wrap (19'h20000) -> bm_rddata=8'h00, no strobes. Also: assert bm_reset while in PEND -> no vid_ack, FSM IDLE after release.
